// File: rtl/sram_rr_arbiter_if.sv
// Bundle between the client ports, the arbiter and the shared single-port SRAM.
// The arbiter takes the slave modport; the client/SRAM side takes the master modport.
interface sram_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // Handshake: requester k presents i_req[k] with i_we/i_addr/i_wdata stable; the access is
  // taken in the cycle where i_req[k] && o_gnt[k]; a read answers with o_rvalid[k] one cycle later.
  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ-1:0]            i_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
  logic [NUM_REQ-1:0]            o_gnt;
  logic [NUM_REQ-1:0]            o_rvalid;
  logic [DATA_WIDTH-1:0]         o_rdata;
  logic [ADDR_WIDTH-1:0]         o_sram_addr;
  logic                          o_sram_write;
  logic [DATA_WIDTH-1:0]         o_sram_wdata;
  logic [DATA_WIDTH-1:0]         i_sram_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_sram_rdata,
    output o_gnt, o_rvalid, o_rdata, o_sram_addr, o_sram_write, o_sram_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_sram_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_sram_addr, o_sram_write, o_sram_wdata
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter with bounded burst hold in front of one single-port synchronous SRAM.
// Define SRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no pointer/burst state).
module sram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  sram_rr_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic [NUM_REQ-1:0]    gnt_vec;
  logic                  rd_gnt;
  logic [NUM_REQ-1:0]    rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_q;
  logic          owner_vld_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          hold;
`endif

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_req[i]) begin
        gnt_idx = IW'(i);
        gnt_any = 1'b1;
      end
    end
`else
    // owner_vld_q is only ever set while the burst still has room, so hold implies cnt_q<MAX_BURST
    hold = owner_vld_q && bus.i_req[owner_q] && (cnt_q < CW'(MAX_BURST));
    if (hold) begin
      gnt_idx = owner_q;
      gnt_any = 1'b1;
    end else begin
      // descending offset so the nearest requester from ptr_q is the last (winning) assignment
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
        if (bus.i_req[(int'(ptr_q) + off) % NUM_REQ]) begin
          gnt_idx = IW'((int'(ptr_q) + off) % NUM_REQ);
          gnt_any = 1'b1;
        end
      end
    end
    cnt_nxt = hold ? cnt_q + CW'(1) : CW'(1);
`endif
    gnt_any = gnt_any & i_rst_n;
    gnt_vec = '0;
    gnt_vec[gnt_idx] = gnt_any;
    rd_gnt = gnt_any & ~bus.i_we[gnt_idx];
  end

  assign bus.o_gnt        = gnt_vec;
  assign bus.o_sram_write = gnt_any & bus.i_we[gnt_idx];
  assign bus.o_sram_addr  = gnt_any ? bus.i_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.o_sram_wdata = gnt_any ? bus.i_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.o_rvalid     = rvalid_q;
  // SRAM data is only valid in the cycle after the read command, so it is forwarded directly
  assign bus.o_rdata      = (|rvalid_q) ? bus.i_sram_rdata : rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q    <= '0;
      rdata_q     <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      rvalid_q <= rd_gnt ? gnt_vec : '0;
      if (|rvalid_q) rdata_q <= bus.i_sram_rdata;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      if (gnt_any) begin
        owner_q     <= gnt_idx;
        ptr_q       <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        cnt_q       <= cnt_nxt;
        owner_vld_q <= (cnt_nxt < CW'(MAX_BURST));
      end else begin
        owner_vld_q <= 1'b0;
        cnt_q       <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Randomized bench driving two arbiters (MAX_BURST 4 and 1) from the same client stimulus,
// each with its own SRAM model, checked against a grant-order / memory reference model.
module tb_sram_rr_arbiter;
  localparam int N    = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MB_A = 4;
  localparam int MB_B = 1;
  localparam int W    = 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req   = '0;
  logic [N-1:0]    we    = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] wdata = '0;

  sram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  sram_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  assign bus_a.i_req   = req;
  assign bus_a.i_we    = we;
  assign bus_a.i_addr  = addr;
  assign bus_a.i_wdata = wdata;
  assign bus_b.i_req   = req;
  assign bus_b.i_we    = we;
  assign bus_b.i_addr  = addr;
  assign bus_b.i_wdata = wdata;

  sram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a.slave)
  );
  sram_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b.slave)
  );

  // single-port synchronous SRAMs behind each arbiter
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  logic [DW-1:0] sram_q_a = '0;
  logic [DW-1:0] sram_q_b = '0;

  always @(posedge clk) begin
    if (bus_a.o_sram_write) mem_a[bus_a.o_sram_addr] <= bus_a.o_sram_wdata;
    sram_q_a <= mem_a[bus_a.o_sram_addr];
    if (bus_b.o_sram_write) mem_b[bus_b.o_sram_addr] <= bus_b.o_sram_wdata;
    sram_q_b <= mem_b[bus_b.o_sram_addr];
  end
  assign bus_a.i_sram_rdata = sram_q_a;
  assign bus_b.i_sram_rdata = sram_q_b;

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [2][256];
  int            last_k  [2];
  int            run_len [2];
  logic [DW-1:0] held    [2];
  logic [W-1:0]  exp_q_a [$];
  logic [W-1:0]  exp_q_b [$];

  function automatic int burst_of(input int d);
    return (d == 0) ? MB_A : MB_B;
  endfunction

  // Grant winner from the rules: stay with the current runner while its run is short enough,
  // otherwise rotate starting just after the last port granted.
  function automatic int model_grant(input int d);
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (req[k]) return k;
    return -1;
`else
    if (run_len[d] > 0 && run_len[d] < burst_of(d) && req[last_k[d]]) return last_k[d];
    for (int off = 1; off <= N; off++) begin
      if (req[(last_k[d] + off) % N]) return (last_k[d] + off) % N;
    end
    return -1;
`endif
  endfunction

  task automatic model_reset(input int d);
    last_k[d]  = N - 1;
    run_len[d] = 0;
    held[d]    = '0;
    if (d == 0) exp_q_a.delete();
    else        exp_q_b.delete();
  endtask

  task automatic check_dut(input int d, input logic [N-1:0] gnt, input logic [N-1:0] rv,
                           input logic [DW-1:0] rd, input logic [AW-1:0] sa,
                           input logic sw, input logic [DW-1:0] swd);
    string        p;
    logic [W-1:0] e;
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_gnt;
    int           g;
    int           ga;
    bit           have;
    p = (d == 0) ? "a" : "b";
    if (!rst_n) begin
      model_reset(d);
      check({p, "_rst_gnt"}, 32'(gnt), 32'd0);
      check({p, "_rst_write"}, 32'(sw), 32'd0);
      check({p, "_rst_rvalid"}, 32'(rv), 32'd0);
      check({p, "_rst_rdata"}, 32'(rd), 32'd0);
      check({p, "_rst_addr"}, 32'(sa), 32'd0);
      return;
    end
    // read return for last cycle's read grant
    have = 1'b0;
    e = '0;
    if (d == 0 && exp_q_a.size() > 0) begin e = exp_q_a.pop_front(); have = 1'b1; end
    if (d == 1 && exp_q_b.size() > 0) begin e = exp_q_b.pop_front(); have = 1'b1; end
    exp_rv = '0;
    if (have) begin
      exp_rv[e[W-1 -: 2]] = 1'b1;
      held[d] = e[DW-1:0];
    end
    check({p, "_rvalid"}, 32'(rv), 32'(exp_rv));
    check({p, "_rdata"}, 32'(rd), 32'(held[d]));
    // grant for the current cycle
    g = model_grant(d);
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check({p, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    if (g < 0) begin
      check({p, "_idle_write"}, 32'(sw), 32'd0);
      check({p, "_idle_addr"}, 32'(sa), 32'd0);
      run_len[d] = 0;
      return;
    end
    check({p, "_sram_addr"}, 32'(sa), 32'(addr[g*AW +: AW]));
    check({p, "_sram_write"}, 32'(sw), 32'(we[g]));
    if (we[g]) begin
      check({p, "_sram_wdata"}, 32'(swd), 32'(wdata[g*DW +: DW]));
      ref_mem[d][addr[g*AW +: AW]] = wdata[g*DW +: DW];
    end else begin
      ga = addr[g*AW +: AW];
      if (d == 0) exp_q_a.push_back({2'(g), ref_mem[d][ga]});
      else        exp_q_b.push_back({2'(g), ref_mem[d][ga]});
    end
    run_len[d] = (g == last_k[d] && run_len[d] > 0 && run_len[d] < burst_of(d)) ? run_len[d] + 1 : 1;
    last_k[d]  = g;
  endtask

  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0, bus_a.o_gnt, bus_a.o_rvalid, bus_a.o_rdata, bus_a.o_sram_addr,
                bus_a.o_sram_write, bus_a.o_sram_wdata);
      check_dut(1, bus_b.o_gnt, bus_b.o_rvalid, bus_b.o_rdata, bus_b.o_sram_addr,
                bus_b.o_sram_write, bus_b.o_sram_wdata);
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int k, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] dt);
    req[k]            = r;
    we[k]             = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = dt;
  endtask

  task automatic rand_ports(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      set_port(k, mask[k], 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)),
               DW'($urandom_range(0, 255)));
    end
  endtask

  task automatic run_mode(input int mode, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      case (mode)
        0:       rand_ports(N'($urandom_range(0, (1 << N) - 1)));
        1:       rand_ports('1);
        2:       rand_ports(N'(4'b0011));
        default: rand_ports(N'(4'b1000));
      endcase
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i]      = '0;
      mem_b[i]      = '0;
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    model_reset(0);
    model_reset(1);
    mon_en = 1'b1;

    // reset held with every port requesting
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, AW'(k), '0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // port 2 writes 0xA5 @0x10, then reads it back
    req = '0;
    set_port(2, 1'b1, 1'b1, 8'h10, 8'hA5);
    step();
    set_port(2, 1'b1, 1'b0, 8'h10, 8'h00);
    step();
    req = '0;
    step();

    // all ports reading, ports 0/1 only, port 3 alone
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, AW'(k + 1), '0);
    repeat (12) step();
    run_mode(2, 16);
    run_mode(3, 10);

    // random segments
    for (int s = 0; s < 120; s++) run_mode($urandom_range(0, 3), $urandom_range(1, 20));

    // reset mid-burst with a read in flight
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b0, AW'(k), '0);
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int s = 0; s < 20; s++) run_mode($urandom_range(0, 3), $urandom_range(1, 20));

    req = '0;
    repeat (2) step();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
